axi4lite_mem_slave: RTL and testbench

Parametrised AXI4-Lite slave bridging a CPU-side AXI4-Lite master to a simple synchronous memory port. It implements all five channels (AR/R/AW/W/B), has independent read and write state machines, and supports a configurable memory read latency, byte strobes, and address-range decode with SLVERR responses. It sits between the core's LSU/IFU AXI master and the memory or device model.

---
 rtl/axi4lite_mem_slave.sv | 200 ++++++++++++++++++++
 tb/tb_axi4lite_mem_slave.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi4lite_mem_slave.sv
// AXI4-Lite slave bridging to a simple synchronous memory port.
// Independent read/write FSMs, fixed read latency, byte strobes, window decode with SLVERR.
module axi4lite_mem_slave #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned RD_LAT     = 1,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = ADDR_WIDTH'(32'h8000_0000),
    parameter logic [ADDR_WIDTH-1:0] SIZE      = ADDR_WIDTH'(32'h0800_0000),
    localparam int unsigned MASK_WIDTH = DATA_WIDTH / 8
) (
    input  logic                  iClock,
    input  logic                  iReset,
    input  logic                  pAXI4_ar_valid,
    input  logic [ADDR_WIDTH-1:0] pAXI4_ar_bits_addr,
    output logic                  pAXI4_ar_ready,
    input  logic                  pAXI4_r_ready,
    output logic                  pAXI4_r_valid,
    output logic [DATA_WIDTH-1:0] pAXI4_r_bits_data,
    output logic [1:0]            pAXI4_r_bits_resp,
    input  logic                  pAXI4_aw_valid,
    input  logic [ADDR_WIDTH-1:0] pAXI4_aw_bits_addr,
    output logic                  pAXI4_aw_ready,
    input  logic                  pAXI4_w_valid,
    input  logic [DATA_WIDTH-1:0] pAXI4_w_bits_data,
    input  logic [MASK_WIDTH-1:0] pAXI4_w_bits_strb,
    output logic                  pAXI4_w_ready,
    input  logic                  pAXI4_b_ready,
    output logic                  pAXI4_b_valid,
    output logic [1:0]            pAXI4_b_bits_resp,
    output logic                  oMemRdEn,
    output logic [ADDR_WIDTH-1:0] oMemRdAddr,
    input  logic [DATA_WIDTH-1:0] iMemRdData,
    input  logic [1:0]            iMemRdResp,
    output logic                  oMemWrEn,
    output logic [ADDR_WIDTH-1:0] oMemWrAddr,
    output logic [DATA_WIDTH-1:0] oMemWrData,
    output logic [MASK_WIDTH-1:0] oMemWrMask
);

    localparam int unsigned EXT_W = ADDR_WIDTH + 1;
    localparam logic [EXT_W-1:0] END_ADDR = EXT_W'(BASE_ADDR) + EXT_W'(SIZE);
    localparam logic [3:0] LAST_CNT = 4'(RD_LAT - 1);
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // End of window is widened by one bit so BASE_ADDR+SIZE cannot wrap.
    function automatic logic in_window(input logic [ADDR_WIDTH-1:0] a);
        return (a >= BASE_ADDR) && (EXT_W'(a) < END_ADDR);
    endfunction

    typedef enum logic [1:0] {R_IDLE, R_ISSUE, R_WAIT, R_RESP} rd_state_e;
    typedef enum logic [1:0] {W_IDLE, W_MEM, W_RESP} wr_state_e;

    rd_state_e             rd_state_q;
    logic                  ar_ready_q;
    logic                  rd_ok_q;
    logic                  rd_en_q;
    logic [ADDR_WIDTH-1:0] rd_addr_q;
    logic [3:0]            rd_cnt_q;
    logic                  r_valid_q;
    logic [DATA_WIDTH-1:0] r_data_q;
    logic [1:0]            r_resp_q;

    wr_state_e             wr_state_q;
    logic                  aw_ready_q;
    logic                  w_ready_q;
    logic                  wr_ok_q;
    logic                  wr_en_q;
    logic [ADDR_WIDTH-1:0] wr_addr_q;
    logic [DATA_WIDTH-1:0] wr_data_q;
    logic [MASK_WIDTH-1:0] wr_mask_q;
    logic                  b_valid_q;
    logic [1:0]            b_resp_q;

    logic aw_fire;
    logic w_fire;
    logic aw_held;
    logic w_held;

    // Read channel: address capture, memory strobe, latency count, response hold.
    always_ff @(posedge iClock) begin
        if (iReset) begin
            rd_state_q <= R_IDLE;
            ar_ready_q <= 1'b1;
            rd_ok_q    <= 1'b0;
            rd_en_q    <= 1'b0;
            rd_addr_q  <= '0;
            rd_cnt_q   <= '0;
            r_valid_q  <= 1'b0;
            r_data_q   <= '0;
            r_resp_q   <= RESP_OKAY;
        end else begin
            case (rd_state_q)
                R_IDLE: begin
                    if (pAXI4_ar_valid) begin
                        ar_ready_q <= 1'b0;
                        rd_addr_q  <= pAXI4_ar_bits_addr;
                        rd_ok_q    <= in_window(pAXI4_ar_bits_addr);
                        rd_en_q    <= in_window(pAXI4_ar_bits_addr);
                        rd_state_q <= R_ISSUE;
                    end
                end
                R_ISSUE: begin
                    rd_en_q    <= 1'b0;
                    rd_cnt_q   <= '0;
                    rd_state_q <= R_WAIT;
                end
                R_WAIT: begin
                    if (rd_cnt_q == LAST_CNT) begin
                        r_data_q   <= rd_ok_q ? iMemRdData : '0;
                        r_resp_q   <= rd_ok_q ? iMemRdResp : RESP_SLVERR;
                        r_valid_q  <= 1'b1;
                        rd_state_q <= R_RESP;
                    end else begin
                        rd_cnt_q <= rd_cnt_q + 4'd1;
                    end
                end
                R_RESP: begin
                    if (pAXI4_r_ready) begin
                        r_valid_q  <= 1'b0;
                        ar_ready_q <= 1'b1;
                        rd_state_q <= R_IDLE;
                    end
                end
                default: rd_state_q <= R_IDLE;
            endcase
        end
    end

    assign aw_fire = pAXI4_aw_valid & aw_ready_q;
    assign w_fire  = pAXI4_w_valid & w_ready_q;
    assign aw_held = aw_fire | ~aw_ready_q;
    assign w_held  = w_fire | ~w_ready_q;

    // Write channel: AW and W captured independently, then one strobe and a B response.
    always_ff @(posedge iClock) begin
        if (iReset) begin
            wr_state_q <= W_IDLE;
            aw_ready_q <= 1'b1;
            w_ready_q  <= 1'b1;
            wr_ok_q    <= 1'b0;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            wr_mask_q  <= '0;
            b_valid_q  <= 1'b0;
            b_resp_q   <= RESP_OKAY;
        end else begin
            case (wr_state_q)
                W_IDLE: begin
                    if (aw_fire) begin
                        aw_ready_q <= 1'b0;
                        wr_addr_q  <= pAXI4_aw_bits_addr;
                        wr_ok_q    <= in_window(pAXI4_aw_bits_addr);
                    end
                    if (w_fire) begin
                        w_ready_q <= 1'b0;
                        wr_data_q <= pAXI4_w_bits_data;
                        wr_mask_q <= pAXI4_w_bits_strb;
                    end
                    if (aw_held && w_held) begin
                        wr_en_q    <= aw_fire ? in_window(pAXI4_aw_bits_addr) : wr_ok_q;
                        wr_state_q <= W_MEM;
                    end
                end
                W_MEM: begin
                    wr_en_q    <= 1'b0;
                    b_valid_q  <= 1'b1;
                    b_resp_q   <= wr_ok_q ? RESP_OKAY : RESP_SLVERR;
                    wr_state_q <= W_RESP;
                end
                W_RESP: begin
                    if (pAXI4_b_ready) begin
                        b_valid_q  <= 1'b0;
                        aw_ready_q <= 1'b1;
                        w_ready_q  <= 1'b1;
                        wr_state_q <= W_IDLE;
                    end
                end
                default: wr_state_q <= W_IDLE;
            endcase
        end
    end

    assign pAXI4_ar_ready    = ar_ready_q;
    assign pAXI4_r_valid     = r_valid_q;
    assign pAXI4_r_bits_data = r_data_q;
    assign pAXI4_r_bits_resp = r_resp_q;
    assign pAXI4_aw_ready    = aw_ready_q;
    assign pAXI4_w_ready     = w_ready_q;
    assign pAXI4_b_valid     = b_valid_q;
    assign pAXI4_b_bits_resp = b_resp_q;
    assign oMemRdEn          = rd_en_q;
    assign oMemRdAddr        = rd_addr_q;
    assign oMemWrEn          = wr_en_q;
    assign oMemWrAddr        = wr_addr_q;
    assign oMemWrData        = wr_data_q;
    assign oMemWrMask        = wr_mask_q;

endmodule

// File: tb/tb_axi4lite_mem_slave.sv
// Bench for axi4lite_mem_slave: two instances (RD_LAT 1 and 4) driven by directed and
// random transactions, checked against cycle-level expectations derived from the window rule.
module tb_axi4lite_mem_slave;

    localparam int LAT0 = 1;
    localparam int LAT1 = 4;
    localparam longint unsigned BASE = 64'h8000_0000;
    localparam longint unsigned SIZE = 64'h0800_0000;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        ar_valid[2];
    logic [31:0] ar_addr[2];
    logic        ar_ready[2];
    logic        r_ready[2];
    logic        r_valid[2];
    logic [63:0] r_data[2];
    logic [1:0]  r_resp[2];
    logic        aw_valid[2];
    logic [31:0] aw_addr[2];
    logic        aw_ready[2];
    logic        w_valid[2];
    logic [63:0] w_data[2];
    logic [7:0]  w_strb[2];
    logic        w_ready[2];
    logic        b_ready[2];
    logic        b_valid[2];
    logic [1:0]  b_resp[2];
    logic        rd_en[2];
    logic [31:0] rd_addr[2];
    logic [63:0] mem_rd_data[2];
    logic [1:0]  mem_rd_resp[2];
    logic        wr_en[2];
    logic [31:0] wr_addr[2];
    logic [63:0] wr_data[2];
    logic [7:0]  wr_mask[2];

    for (genvar g = 0; g < 2; g++) begin : g_dut
        axi4lite_mem_slave #(.RD_LAT(g == 0 ? LAT0 : LAT1)) u_dut (
            .iClock(clk), .iReset(rst),
            .pAXI4_ar_valid(ar_valid[g]), .pAXI4_ar_bits_addr(ar_addr[g]), .pAXI4_ar_ready(ar_ready[g]),
            .pAXI4_r_ready(r_ready[g]), .pAXI4_r_valid(r_valid[g]),
            .pAXI4_r_bits_data(r_data[g]), .pAXI4_r_bits_resp(r_resp[g]),
            .pAXI4_aw_valid(aw_valid[g]), .pAXI4_aw_bits_addr(aw_addr[g]), .pAXI4_aw_ready(aw_ready[g]),
            .pAXI4_w_valid(w_valid[g]), .pAXI4_w_bits_data(w_data[g]),
            .pAXI4_w_bits_strb(w_strb[g]), .pAXI4_w_ready(w_ready[g]),
            .pAXI4_b_ready(b_ready[g]), .pAXI4_b_valid(b_valid[g]), .pAXI4_b_bits_resp(b_resp[g]),
            .oMemRdEn(rd_en[g]), .oMemRdAddr(rd_addr[g]),
            .iMemRdData(mem_rd_data[g]), .iMemRdResp(mem_rd_resp[g]),
            .oMemWrEn(wr_en[g]), .oMemWrAddr(wr_addr[g]),
            .oMemWrData(wr_data[g]), .oMemWrMask(wr_mask[g])
        );
    end

    // Memory model: the word is valid only in the cycle exactly RD_LAT after the strobe.
    logic [63:0] mem_word[2];
    logic [1:0]  mem_word_resp[2];
    int          mem_cnt[2] = '{0, 0};

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (rd_en[i]) mem_cnt[i] <= (i == 0) ? LAT0 : LAT1;
            else if (mem_cnt[i] > 0) mem_cnt[i] <= mem_cnt[i] - 1;
        end
    end

    always_comb begin
        for (int i = 0; i < 2; i++) begin
            mem_rd_data[i] = (mem_cnt[i] == 1) ? mem_word[i] : 64'hBADB_ADBA_DBAD_BAD0;
            mem_rd_resp[i] = (mem_cnt[i] == 1) ? mem_word_resp[i] : 2'b11;
        end
    end

    int errors = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic bit in_win(input logic [31:0] a);
        longint unsigned x;
        x = 64'(a);
        return (x >= BASE) && (x < BASE + SIZE);
    endfunction

    // One read: AR in the current cycle, r_ready held low for 'hold' cycles after r_valid.
    task automatic do_read(input int i, input logic [31:0] addr, input logic [63:0] data,
                           input logic [1:0] resp, input int hold);
        bit          ok;
        int          lat;
        logic [63:0] exp_d;
        logic [1:0]  exp_r;
        ok    = in_win(addr);
        lat   = (i == 0) ? LAT0 : LAT1;
        exp_d = ok ? data : 64'd0;
        exp_r = ok ? resp : 2'b10;
        mem_word[i]      = data;
        mem_word_resp[i] = resp;
        chk("ar_ready_idle", 64'(ar_ready[i]), 64'd1);
        ar_valid[i] = 1'b1;
        ar_addr[i]  = addr;
        step();
        ar_valid[i] = 1'b0;
        ar_addr[i]  = $urandom;
        chk("rd_en_issue", 64'(rd_en[i]), 64'(ok));
        if (ok) chk("rd_addr", 64'(rd_addr[i]), 64'(addr));
        chk("ar_ready_busy", 64'(ar_ready[i]), 64'd0);
        for (int k = 0; k < lat; k++) begin
            step();
            chk("rd_en_wait", 64'(rd_en[i]), 64'd0);
            chk("r_valid_early", 64'(r_valid[i]), 64'd0);
            chk("ar_ready_wait", 64'(ar_ready[i]), 64'd0);
        end
        step();
        for (int k = 0; k <= hold; k++) begin
            chk("r_valid", 64'(r_valid[i]), 64'd1);
            chk("r_data", r_data[i], exp_d);
            chk("r_resp", 64'(r_resp[i]), 64'(exp_r));
            chk("ar_ready_resp", 64'(ar_ready[i]), 64'd0);
            if (k < hold) step();
        end
        r_ready[i] = 1'b1;
        step();
        r_ready[i] = 1'b0;
        chk("r_valid_done", 64'(r_valid[i]), 64'd0);
        chk("ar_ready_done", 64'(ar_ready[i]), 64'd1);
    endtask

    // One write: AW offered in cycle aw_dl, W in cycle w_dl, b_ready low for 'hold' cycles.
    task automatic do_write(input int i, input logic [31:0] addr, input logic [63:0] data,
                            input logic [7:0] strb, input int aw_dl, input int w_dl, input int hold);
        bit ok;
        int last;
        ok   = in_win(addr);
        last = (aw_dl > w_dl) ? aw_dl : w_dl;
        for (int c = 0; c <= last; c++) begin
            chk("aw_ready_pre", 64'(aw_ready[i]), 64'(c <= aw_dl));
            chk("w_ready_pre", 64'(w_ready[i]), 64'(c <= w_dl));
            chk("wr_en_pre", 64'(wr_en[i]), 64'd0);
            chk("b_valid_pre", 64'(b_valid[i]), 64'd0);
            aw_valid[i] = (c == aw_dl);
            aw_addr[i]  = (c == aw_dl) ? addr : $urandom;
            w_valid[i]  = (c == w_dl);
            w_data[i]   = (c == w_dl) ? data : {$urandom, $urandom};
            w_strb[i]   = (c == w_dl) ? strb : 8'($urandom);
            step();
        end
        aw_valid[i] = 1'b0;
        w_valid[i]  = 1'b0;
        w_data[i]   = {$urandom, $urandom};
        chk("wr_en_mem", 64'(wr_en[i]), 64'(ok));
        chk("wr_addr", 64'(wr_addr[i]), 64'(addr));
        chk("wr_data", wr_data[i], data);
        chk("wr_mask", 64'(wr_mask[i]), 64'(strb));
        chk("b_valid_mem", 64'(b_valid[i]), 64'd0);
        chk("aw_ready_mem", 64'(aw_ready[i]), 64'd0);
        chk("w_ready_mem", 64'(w_ready[i]), 64'd0);
        step();
        for (int k = 0; k <= hold; k++) begin
            chk("b_valid", 64'(b_valid[i]), 64'd1);
            chk("b_resp", 64'(b_resp[i]), ok ? 64'd0 : 64'd2);
            chk("wr_en_resp", 64'(wr_en[i]), 64'd0);
            chk("aw_ready_resp", 64'(aw_ready[i]), 64'd0);
            chk("w_ready_resp", 64'(w_ready[i]), 64'd0);
            if (k < hold) step();
        end
        b_ready[i] = 1'b1;
        step();
        b_ready[i] = 1'b0;
        chk("b_valid_done", 64'(b_valid[i]), 64'd0);
        chk("aw_ready_done", 64'(aw_ready[i]), 64'd1);
        chk("w_ready_done", 64'(w_ready[i]), 64'd1);
    endtask

    task automatic chk_idle(input int i, input string tag);
        chk({tag, "_ar_ready"}, 64'(ar_ready[i]), 64'd1);
        chk({tag, "_aw_ready"}, 64'(aw_ready[i]), 64'd1);
        chk({tag, "_w_ready"}, 64'(w_ready[i]), 64'd1);
        chk({tag, "_r_valid"}, 64'(r_valid[i]), 64'd0);
        chk({tag, "_b_valid"}, 64'(b_valid[i]), 64'd0);
        chk({tag, "_rd_en"}, 64'(rd_en[i]), 64'd0);
        chk({tag, "_wr_en"}, 64'(wr_en[i]), 64'd0);
    endtask

    initial begin
        logic [31:0] a;
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            ar_valid[i] = 1'b0; ar_addr[i] = '0; r_ready[i] = 1'b0;
            aw_valid[i] = 1'b0; aw_addr[i] = '0; w_valid[i] = 1'b0;
            w_data[i] = '0; w_strb[i] = '0; b_ready[i] = 1'b0;
            mem_word[i] = '0; mem_word_resp[i] = 2'b00;
        end
        step();
        step();
        for (int i = 0; i < 2; i++) begin
            chk_idle(i, "reset");
            chk("reset_r_data", r_data[i], 64'd0);
            chk("reset_r_resp", 64'(r_resp[i]), 64'd0);
            chk("reset_b_resp", 64'(b_resp[i]), 64'd0);
            chk("reset_rd_addr", 64'(rd_addr[i]), 64'd0);
            chk("reset_wr_addr", 64'(wr_addr[i]), 64'd0);
            chk("reset_wr_data", wr_data[i], 64'd0);
            chk("reset_wr_mask", 64'(wr_mask[i]), 64'd0);
        end
        rst = 1'b0;
        step();

        // Basic reads at both latencies, including a long r_ready stall
        do_read(0, 32'h8000_0010, 64'h1122_3344_5566_7788, 2'b00, 0);
        do_read(1, 32'h8000_0020, 64'hCAFE_F00D_0123_4567, 2'b00, 5);
        do_read(1, 32'h8000_0028, 64'h0F0F_0F0F_F0F0_F0F0, 2'b01, 2);

        // W three cycles before AW, and the reverse
        do_write(0, 32'h8000_0100, 64'hDEAD_BEEF_0000_0001, 8'h0F, 3, 0, 0);
        do_write(1, 32'h8000_0108, 64'h0123_4567_89AB_CDEF, 8'hF0, 0, 2, 3);

        // Out-of-range and window boundaries
        do_read(0, 32'h1000_0000, 64'h5555_AAAA_5555_AAAA, 2'b00, 1);
        do_read(1, 32'h1000_0000, 64'h5555_AAAA_5555_AAAA, 2'b00, 0);
        do_write(0, 32'h8800_0000, 64'hFFFF_0000_FFFF_0000, 8'hFF, 0, 0, 1);
        do_read(0, 32'h7FFF_FFF8, 64'h1, 2'b00, 0);
        do_read(0, 32'h8000_0000, 64'h2, 2'b00, 0);
        do_read(0, 32'h87FF_FFF8, 64'h3, 2'b00, 0);
        do_read(0, 32'h8800_0000, 64'h4, 2'b00, 0);
        do_write(1, 32'h87FF_FFF8, 64'h5, 8'h81, 1, 1, 0);
        do_write(1, 32'hFFFF_FFF8, 64'h6, 8'h01, 0, 1, 0);

        // Concurrent AR and AW+W in the same cycle on the RD_LAT=1 instance
        mem_word[0] = 64'hA5A5_5A5A_1234_8765;
        mem_word_resp[0] = 2'b00;
        ar_valid[0] = 1'b1; ar_addr[0] = 32'h8000_0400;
        aw_valid[0] = 1'b1; aw_addr[0] = 32'h8000_0408;
        w_valid[0] = 1'b1; w_data[0] = 64'h7777_8888_9999_AAAA; w_strb[0] = 8'h3C;
        step();
        ar_valid[0] = 1'b0; aw_valid[0] = 1'b0; w_valid[0] = 1'b0;
        chk("conc_rd_en", 64'(rd_en[0]), 64'd1);
        chk("conc_wr_en", 64'(wr_en[0]), 64'd1);
        chk("conc_rd_addr", 64'(rd_addr[0]), 64'h8000_0400);
        chk("conc_wr_addr", 64'(wr_addr[0]), 64'h8000_0408);
        chk("conc_wr_data", wr_data[0], 64'h7777_8888_9999_AAAA);
        chk("conc_wr_mask", 64'(wr_mask[0]), 64'h3C);
        step();
        chk("conc_b_valid", 64'(b_valid[0]), 64'd1);
        chk("conc_r_valid_early", 64'(r_valid[0]), 64'd0);
        step();
        chk("conc_r_valid", 64'(r_valid[0]), 64'd1);
        chk("conc_r_data", r_data[0], 64'hA5A5_5A5A_1234_8765);
        chk("conc_b_held", 64'(b_valid[0]), 64'd1);
        chk("conc_b_resp", 64'(b_resp[0]), 64'd0);
        r_ready[0] = 1'b1; b_ready[0] = 1'b1;
        step();
        r_ready[0] = 1'b0; b_ready[0] = 1'b0;
        chk_idle(0, "conc_done");

        // Reset while the RD_LAT=4 instance is in R_WAIT and W_RESP
        aw_valid[1] = 1'b1; aw_addr[1] = 32'h8000_0200;
        w_valid[1] = 1'b1; w_data[1] = 64'h1; w_strb[1] = 8'hFF;
        step();
        aw_valid[1] = 1'b0; w_valid[1] = 1'b0;
        ar_valid[1] = 1'b1; ar_addr[1] = 32'h8000_0300;
        step();
        ar_valid[1] = 1'b0;
        chk("rst_pre_b_valid", 64'(b_valid[1]), 64'd1);
        chk("rst_pre_rd_en", 64'(rd_en[1]), 64'd1);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk_idle(1, "rst_mid");
        chk_idle(0, "rst_mid_other");
        step();
        chk_idle(1, "rst_after");
        do_read(1, 32'h8000_0300, 64'h0BAD_C0DE_FEED_BEEF, 2'b00, 1);

        // Random traffic on both instances
        for (int n = 0; n < 24; n++) begin
            int i;
            i = n % 2;
            if ($urandom_range(0, 3) == 0) a = $urandom & 32'hFFFF_FFF8;
            else a = 32'(BASE + 64'($urandom_range(0, 32'(SIZE / 8) - 1)) * 8);
            if ($urandom_range(0, 1) == 0)
                do_read(i, a, {$urandom, $urandom}, 2'($urandom_range(0, 1)), $urandom_range(0, 3));
            else
                do_write(i, a, {$urandom, $urandom}, 8'($urandom), $urandom_range(0, 3),
                         $urandom_range(0, 3), $urandom_range(0, 3));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
